// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM 5-stage pipeline hazard controller.
package arm_pipe_pkg;

  localparam int unsigned CNT_W      = 3;
  localparam int unsigned PERF_W     = 32;
  localparam int unsigned PC_REG_IDX = 15;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  // Pipeline sequencing controls driven by the controller each cycle.
  typedef struct packed {
    logic pc_enable;
    logic pc_sel_branch;
    logic if_id_enable;
    logic if_id_flush;
    logic cu_bubble;
    logic pipe_hold;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-operand forwarding selects and load-use hazard detect.
module hazard_fwd_unit
  import arm_pipe_pkg::*;
#(
  parameter int unsigned REG_W = 4
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             load_use
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG_IDX);

  logic rn_mem, rn_wb, rm_mem, rm_wb;
  logic rn_dep, rm_dep;

  // The PC is never a forwarding target: reads of r15 always come from the register file.
  assign rn_mem = mem_reg_write && (mem_rd == id_rn) && (id_rn != PC_IDX);
  assign rn_wb  = wb_reg_write  && (wb_rd  == id_rn) && (id_rn != PC_IDX);
  assign rm_mem = mem_reg_write && (mem_rd == id_rm) && (id_rm != PC_IDX);
  assign rm_wb  = wb_reg_write  && (wb_rd  == id_rm) && (id_rm != PC_IDX);

  assign fwd_a_sel = rn_mem ? FWD_MEM : (rn_wb ? FWD_WB : FWD_REG);
  assign fwd_b_sel = rm_mem ? FWD_MEM : (rm_wb ? FWD_WB : FWD_REG);

  assign rn_dep   = id_uses_rn && (id_rn == ex_rd);
  assign rm_dep   = id_uses_rm && (id_rm == ex_rd);
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != PC_IDX) && (rn_dep || rm_dep);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for the 5-stage ARM pipeline: load-use stall, branch squash, memory freeze.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int unsigned LOAD_LATENCY   = 1,
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned REG_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic              id_uses_rn,
  input  logic              id_uses_rm,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              wb_reg_write,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_enable,
  output logic              pc_sel_branch,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              cu_bubble,
  output logic              pipe_hold,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_cycles,
  output logic [PERF_W-1:0] freeze_cycles
`endif
);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 7) begin : g_bad_load_latency
    $error("pipeline_hazard_controller: LOAD_LATENCY must be in 1..7");
  end
  if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 7) begin : g_bad_branch_penalty
    $error("pipeline_hazard_controller: BRANCH_PENALTY must be in 1..7");
  end

  localparam logic [CNT_W-1:0] LL_RELOAD = CNT_W'(LOAD_LATENCY - 1);
  localparam logic [CNT_W-1:0] BP_RELOAD = CNT_W'(BRANCH_PENALTY - 1);
  localparam logic             LL_MULTI  = (LOAD_LATENCY > 1);
  localparam logic             BP_MULTI  = (BRANCH_PENALTY > 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam hz_ctrl_t CTRL_RESET  = '{cu_bubble: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_RUN    = '{pc_enable: 1'b1, if_id_enable: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pipe_hold: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_STALL  = '{cu_bubble: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH  = '{pc_enable: 1'b1, if_id_flush: 1'b1, cu_bubble: 1'b1,
                                       default: 1'b0};
  localparam hz_ctrl_t CTRL_BRANCH = '{pc_enable: 1'b1, pc_sel_branch: 1'b1, if_id_flush: 1'b1,
                                       cu_bubble: 1'b1, default: 1'b0};

  hz_state_t        state_q, state_d, save_state_q, save_state_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, save_cnt_q, save_cnt_d, eff_cnt;
  logic             init_q;
  logic             in_reset;
  hz_ctrl_t         ctrl;
  logic             stall_act, flush_act, freeze_act;
  logic             load_use;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd (
    .id_rn         (id_rn),
    .id_rm         (id_rm),
    .id_uses_rn    (id_uses_rn),
    .id_uses_rm    (id_uses_rm),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a_sel     (fwd_a_raw),
    .fwd_b_sel     (fwd_b_raw),
    .load_use      (load_use)
  );

  // Reset values persist for one extra cycle after reset falls (init_q).
  assign in_reset = reset || init_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      save_state_q <= RUN;
      save_cnt_q   <= '0;
      init_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      save_state_q <= save_state_d;
      save_cnt_q   <= save_cnt_d;
      init_q       <= 1'b0;
    end
  end

  // Leaving MEM_WAIT, the saved state acts in the same cycle mem_busy drops.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    save_state_d = save_state_q;
    save_cnt_d   = save_cnt_q;
    ctrl         = CTRL_RESET;
    stall_act    = 1'b0;
    flush_act    = 1'b0;
    freeze_act   = 1'b0;
    eff_state    = state_q;
    eff_cnt      = cnt_q;
    if (state_q == MEM_WAIT) begin
      eff_state = save_state_q;
      eff_cnt   = save_cnt_q;
    end

    if (in_reset) begin
      state_d      = RUN;
      cnt_d        = '0;
      save_state_d = RUN;
      save_cnt_d   = '0;
    end else if (mem_busy) begin
      ctrl       = CTRL_FREEZE;
      freeze_act = 1'b1;
      if (state_q != MEM_WAIT) begin
        save_state_d = state_q;
        save_cnt_d   = cnt_q;
        state_d      = MEM_WAIT;
      end
    end else if (branch_taken) begin
      ctrl      = CTRL_BRANCH;
      flush_act = 1'b1;
      state_d   = BP_MULTI ? BR_FLUSH : RUN;
      cnt_d     = BP_MULTI ? BP_RELOAD : '0;
    end else begin
      state_d = RUN;
      cnt_d   = '0;
      case (eff_state)
        LOAD_STALL: begin
          ctrl      = CTRL_STALL;
          stall_act = 1'b1;
          if (eff_cnt != CNT_ONE) begin
            state_d = LOAD_STALL;
            cnt_d   = eff_cnt - CNT_ONE;
          end
        end
        BR_FLUSH: begin
          ctrl      = CTRL_FLUSH;
          flush_act = 1'b1;
          if (eff_cnt != CNT_ONE) begin
            state_d = BR_FLUSH;
            cnt_d   = eff_cnt - CNT_ONE;
          end
        end
        default: begin
          if (load_use) begin
            ctrl      = CTRL_STALL;
            stall_act = 1'b1;
            if (LL_MULTI) begin
              state_d = LOAD_STALL;
              cnt_d   = LL_RELOAD;
            end
          end else begin
            ctrl = CTRL_RUN;
          end
        end
      endcase
    end
  end

  assign pc_enable     = ctrl.pc_enable;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign if_id_enable  = ctrl.if_id_enable;
  assign if_id_flush   = ctrl.if_id_flush;
  assign cu_bubble     = ctrl.cu_bubble;
  assign pipe_hold     = ctrl.pipe_hold;
  assign fwd_a_sel     = in_reset ? FWD_REG : fwd_a_raw;
  assign fwd_b_sel     = in_reset ? FWD_REG : fwd_b_raw;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating occupancy counters for stall, flush and freeze cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      flush_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (stall_act && (stall_cycles != '1))   stall_cycles  <= stall_cycles + PERF_W'(1);
      if (flush_act && (flush_cycles != '1))   flush_cycles  <= flush_cycles + PERF_W'(1);
      if (freeze_act && (freeze_cycles != '1)) freeze_cycles <= freeze_cycles + PERF_W'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{stall_act, flush_act, freeze_act};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two parameterisations driven by shared stimulus,
// checked against a remaining-cycles reference model. Perf counters checked under HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_controller;

  localparam int unsigned REG_W = 4;
  localparam int LL0 = 1, BP0 = 2;
  localparam int LL1 = 4, BP1 = 3;

  // ctrl vector = {pc_enable, pc_sel_branch, if_id_enable, if_id_flush, cu_bubble, pipe_hold}
  localparam logic [5:0] E_RESET  = 6'b000010;
  localparam logic [5:0] E_RUN    = 6'b101000;
  localparam logic [5:0] E_FREEZE = 6'b000001;
  localparam logic [5:0] E_STALL  = 6'b000010;
  localparam logic [5:0] E_FLUSH  = 6'b100110;
  localparam logic [5:0] E_BRANCH = 6'b110110;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic id_uses_rn, id_uses_rm, ex_reg_write, ex_mem_read;
  logic mem_reg_write, wb_reg_write, branch_taken, mem_busy;

  logic [1:0] pc_enable, pc_sel_branch, if_id_enable, if_id_flush, cu_bubble, pipe_hold;
  logic [1:0] fwd_a [2];
  logic [1:0] fwd_b [2];
  logic [31:0] stall_cyc [2];
  logic [31:0] flush_cyc [2];
  logic [31:0] freeze_cyc [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining extra stall/flush cycles and post-reset bubble flag.
  int m_stall [2];
  int m_flush [2];
  bit m_post [2];
  int m_stall_cnt [2];
  int m_flush_cnt [2];
  int m_freeze_cnt [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipeline_hazard_controller #(
      .LOAD_LATENCY   ((g == 0) ? LL0 : LL1),
      .BRANCH_PENALTY ((g == 0) ? BP0 : BP1),
      .REG_W          (REG_W)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .id_rn         (id_rn),
      .id_rm         (id_rm),
      .id_uses_rn    (id_uses_rn),
      .id_uses_rm    (id_uses_rm),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .branch_taken  (branch_taken),
      .mem_busy      (mem_busy),
      .pc_enable     (pc_enable[g]),
      .pc_sel_branch (pc_sel_branch[g]),
      .if_id_enable  (if_id_enable[g]),
      .if_id_flush   (if_id_flush[g]),
      .cu_bubble     (cu_bubble[g]),
      .pipe_hold     (pipe_hold[g]),
      .fwd_a_sel     (fwd_a[g]),
      .fwd_b_sel     (fwd_b[g])
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles  (stall_cyc[g]),
      .flush_cycles  (flush_cyc[g]),
      .freeze_cycles (freeze_cyc[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [REG_W-1:0] src);
    if (src == 4'd15) return 2'b00;
    if (mem_reg_write && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Check both DUTs against the model for the current inputs, then advance one clock.
  task automatic cycle();
    int ll, bp;
    logic [5:0] e_ctrl, o_ctrl;
    logic [1:0] e_fa, e_fb;
    bit st, fl, fz, lu;
    @(negedge clk);
    lu = ex_mem_read && ex_reg_write && (ex_rd != 4'd15) &&
         ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
    for (int i = 0; i < 2; i++) begin
      ll = (i == 0) ? LL0 : LL1;
      bp = (i == 0) ? BP0 : BP1;
      st = 1'b0; fl = 1'b0; fz = 1'b0;
      e_fa = 2'b00; e_fb = 2'b00;
      if (reset || m_post[i]) begin
        e_ctrl = E_RESET;
      end else begin
        e_fa = fwd_ref(id_rn);
        e_fb = fwd_ref(id_rm);
        if (mem_busy) begin
          e_ctrl = E_FREEZE; fz = 1'b1;
        end else if (branch_taken) begin
          e_ctrl = E_BRANCH; fl = 1'b1; m_flush[i] = bp - 1; m_stall[i] = 0;
        end else if (m_flush[i] > 0) begin
          e_ctrl = E_FLUSH; fl = 1'b1; m_flush[i]--;
        end else if (m_stall[i] > 0) begin
          e_ctrl = E_STALL; st = 1'b1; m_stall[i]--;
        end else if (lu) begin
          e_ctrl = E_STALL; st = 1'b1; m_stall[i] = ll - 1;
        end else begin
          e_ctrl = E_RUN;
        end
      end
      o_ctrl = {pc_enable[i], pc_sel_branch[i], if_id_enable[i], if_id_flush[i],
                cu_bubble[i], pipe_hold[i]};
      check($sformatf("dut%0d ctrl", i), 32'(o_ctrl), 32'(e_ctrl));
      check($sformatf("dut%0d fwd_a", i), 32'(fwd_a[i]), 32'(e_fa));
      check($sformatf("dut%0d fwd_b", i), 32'(fwd_b[i]), 32'(e_fb));
`ifdef HAZARD_PERF_CNT_EN
      if (!reset) begin
        check($sformatf("dut%0d stall_cycles", i), stall_cyc[i], 32'(m_stall_cnt[i]));
        check($sformatf("dut%0d flush_cycles", i), flush_cyc[i], 32'(m_flush_cnt[i]));
        check($sformatf("dut%0d freeze_cycles", i), freeze_cyc[i], 32'(m_freeze_cnt[i]));
      end
`endif
      if (reset) begin
        m_stall[i] = 0; m_flush[i] = 0; m_post[i] = 1'b1;
        m_stall_cnt[i] = 0; m_flush_cnt[i] = 0; m_freeze_cnt[i] = 0;
      end else begin
        m_post[i] = 1'b0;
        m_stall_cnt[i] += int'(st);
        m_flush_cnt[i] += int'(fl);
        m_freeze_cnt[i] += int'(fz);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0;
    id_rn = '0; id_rm = '0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  function automatic logic [REG_W-1:0] pick_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : REG_W'(r);
  endfunction

  task automatic rand_inputs();
    reset         = ($urandom_range(0, 99) < 1);
    id_rn         = pick_reg();
    id_rm         = pick_reg();
    id_uses_rn    = $urandom_range(0, 1) == 1;
    id_uses_rm    = $urandom_range(0, 1) == 1;
    ex_rd         = pick_reg();
    ex_reg_write  = $urandom_range(0, 3) != 0;
    ex_mem_read   = $urandom_range(0, 2) == 0;
    mem_rd        = pick_reg();
    mem_reg_write = $urandom_range(0, 1) == 1;
    wb_rd         = pick_reg();
    wb_reg_write  = $urandom_range(0, 1) == 1;
    branch_taken  = $urandom_range(0, 9) == 0;
    mem_busy      = $urandom_range(0, 99) < 15;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_stall[i] = 0; m_flush[i] = 0; m_post[i] = 1'b0;
      m_stall_cnt[i] = 0; m_flush_cnt[i] = 0; m_freeze_cnt[i] = 0;
    end
    set_idle();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (3) cycle();

    // Load-use on rn, then the load reaches MEM and forwards to operand A.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd2; id_rn = 4'd2; id_uses_rn = 1'b1;
    cycle();
    set_idle();
    mem_rd = 4'd2; mem_reg_write = 1'b1; id_rn = 4'd2;
    cycle();
    set_idle();
    repeat (4) cycle();

    // Taken branch pulse.
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    repeat (4) cycle();

    // Memory wait in the middle of a branch flush.
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    mem_busy = 1'b1;
    repeat (3) cycle();
    mem_busy = 1'b0;
    repeat (3) cycle();

    // MEM has priority over WB; r15 never forwards.
    mem_rd = 4'd5; wb_rd = 4'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    id_rn = 4'd5; id_rm = 4'd15;
    cycle();
    wb_rd = 4'd7; id_rm = 4'd7;
    cycle();
    set_idle();

    // Reset in the middle of a multi-cycle load stall.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3; id_rm = 4'd3; id_uses_rm = 1'b1;
    cycle();
    set_idle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end
    set_idle();
    repeat (8) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
